wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
- Sequences the single register-file write port between the short pipe (ALU result from ID/EX, LSU load writeback) and the long pipe (MDU).
- The short pipe always wins the port. Colliding MDU results are parked in a small FIFO and drained on idle writeback cycles. When the FIFO cannot accept, the MDU is back-pressured.
- Sits between EX/LSU/MDU and the register file / CSR retire counter.

Parameters:
- XLEN, 32, data width.
- REG_SIZE, 5, register index width.
- MDU_Q_DEPTH, 2, MDU result FIFO entries (>=1).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- error_from_eiu  in  1  squash short-pipe write this cycle
- alu_wb_en  in  1  ALU writeback request
- alu_rd  in  REG_SIZE  ALU destination
- alu_data  in  XLEN  ALU result
- lsu_wb_en  in  1  LSU load writeback request
- lsu_rd  in  REG_SIZE  LSU destination
- lsu_data  in  XLEN  load data
- lsu_retire  in  1  store/load success pulse
- mdu_finish  in  1  MDU result valid
- mdu_rd  in  REG_SIZE  MDU destination
- mdu_data  in  XLEN  MDU result
- mdu_ready  out  1  MDU result accepted this cycle
- rd_en_to_reg  out  1  register write enable (registered)
- rd_index_to_reg  out  REG_SIZE  write index (registered)
- rd_data_to_reg  out  XLEN  write data (registered)
- inst_finish_to_csr  out  1  retire pulse (registered)
- mdu_q_count  out  clog2(MDU_Q_DEPTH+1)  FIFO occupancy
- rs1_q  in  REG_SIZE  hazard query (optional feature)
- rs2_q  in  REG_SIZE  hazard query (optional feature)
- raw_hazard  out  1  query hit in FIFO (optional feature)

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - FIFO emptied.
  - rd_en_to_reg=0, rd_index_to_reg=0, rd_data_to_reg=0, inst_finish_to_csr=0.
  - mdu_q_count=0.
  - mdu_ready=1 combinationally after reset.
  - Reset mid-operation discards queued MDU results.
- Short request:
  - short = (alu_wb_en | lsu_wb_en) & ~error_from_eiu.
  - ALU beats LSU. Both asserted together is a protocol violation (simulation assertion); ALU is written and LSU is dropped.
- Port selection each cycle, in priority order:
  1. Short request → short source selected.
  2. Else FIFO non-empty → FIFO head popped.
  3. Else mdu_finish & empty → MDU bypasses the FIFO directly.
  4. Else no write.
- MDU acceptance:
  - mdu_ready = (count < MDU_Q_DEPTH) | ~short.
  - Accepted MDU results not written this cycle are pushed to the FIFO tail.
  - Push and pop in the same cycle leave count unchanged. This is legal when full only if a pop occurs.
  - MDU holds mdu_finish/rd/data stable until mdu_ready=1.
- Output timing:
  - Selected write appears on the *_to_reg outputs the next cycle (latency 1).
  - Writes with index 0 drive rd_en_to_reg=0 but still count as retire.
- Retire:
  - inst_finish_to_csr (next cycle) = any selected write | alu_wb_en & ~error | lsu_retire.
  - A single pulse per cycle is emitted even if multiple sources are active.
- FIFO ordering:
  - FIFO is strictly FIFO; wrap-around of the read/write pointers is modulo MDU_Q_DEPTH.
  - Overflow is impossible by construction. Pop on empty never occurs.

Optional Feature:
- Macro: WB_RAW_CHECK_EN.
- When defined:
  - raw_hazard = 1 if any valid FIFO entry, or the MDU result being enqueued this cycle, has a nonzero rd equal to rs1_q or rs2_q.
  - Comparison is combinational.
- When undefined:
  - rs1_q/rs2_q are ignored and raw_hazard is tied 0.
  - No comparators are synthesised.

Decomposition:
- Shared package/defines: ZCRV_XLEN and ZCRV_REG_SIZE widths, WB_SRC encoding (NONE/ALU/LSU/MDUQ/MDUBYP).
- One natural sub-module, wb_mdu_fifo: parameterised depth, push/pop/count, and per-entry rd exposure for the hazard check.

Test Plan:
- ALU write x5=0x11 with no MDU activity → next cycle rd_en=1, idx=5, data=0x11, finish=1.
- mdu_finish x7=0xAA while ALU writes x3 → cycle+1 x3 written, count=1. Next idle cycle → cycle+1 x7=0xAA written, count=0.
- ALU busy 4 consecutive cycles, MDU finishes x8, then x9, then x10 (DEPTH=2) → count reaches 2, mdu_ready=0 while x10 is pending. Drain order is x8, x9, x10.
- error_from_eiu=1 with alu_wb_en x4 and mdu_finish x6 → x4 suppressed, x6 written via bypass, finish=1.
- rst asserted with count=2 → after reset count=0, no stale writes, rd_en=0.
- WB_RAW_CHECK_EN: queued x9 with rs1_q=9 → raw_hazard=1. With rs1_q=0 and queued x0 → raw_hazard=0.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// Shared widths and write-port source encoding for the writeback arbiter.
package wb_arbiter_pkg;

   localparam int ZCRV_XLEN     = 32;
   localparam int ZCRV_REG_SIZE = 5;

   // Which producer owns the register-file write port in a given cycle.
   typedef enum logic [2:0] {
      WB_SRC_NONE   = 3'd0,
      WB_SRC_ALU    = 3'd1,
      WB_SRC_LSU    = 3'd2,
      WB_SRC_MDUQ   = 3'd3,
      WB_SRC_MDUBYP = 3'd4
   } wb_src_e;

   // True when the selected source produces a register-file write.
   function automatic logic wb_src_writes(input wb_src_e src);
      return (src != WB_SRC_NONE);
   endfunction

endpackage

// File: rtl/wb_arbiter_chk.sv
// Protocol checks for the writeback arbiter: short-pipe sources are
// mutually exclusive and the MDU FIFO never over- or underflows.
module wb_arbiter_chk (
   input logic clk,
   input logic rst,
   input logic alu_wb_en,
   input logic lsu_wb_en,
   input logic push,
   input logic pop,
   input logic full,
   input logic empty
);

   a_short_exclusive: assert property (@(posedge clk) disable iff (rst)
      !(alu_wb_en && lsu_wb_en));

   a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(push && full && !pop));

   a_no_underflow: assert property (@(posedge clk) disable iff (rst)
      !(pop && empty));

endmodule

// File: rtl/wb_mdu_fifo.sv
// Small circular FIFO that parks MDU results which lost the write port.
// Pointers wrap modulo DEPTH, so DEPTH need not be a power of two.
// Per-entry valid/rd are exposed so the top level can run a RAW check.
module wb_mdu_fifo
   import wb_arbiter_pkg::*;
#(
   parameter int XLEN     = ZCRV_XLEN,
   parameter int REG_SIZE = ZCRV_REG_SIZE,
   parameter int DEPTH    = 2,
   localparam int CNT_W   = $clog2(DEPTH + 1),
   localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           push_i,
   input  logic [REG_SIZE-1:0]            push_rd_i,
   input  logic [XLEN-1:0]                push_data_i,
   input  logic                           pop_i,
   output logic [REG_SIZE-1:0]            head_rd_o,
   output logic [XLEN-1:0]                head_data_o,
   output logic [CNT_W-1:0]               count_o,
   output logic                           empty_o,
   output logic                           full_o,
   output logic [DEPTH-1:0]               entry_valid_o,
   output logic [DEPTH-1:0][REG_SIZE-1:0] entry_rd_o
);

   logic [DEPTH-1:0][REG_SIZE-1:0] rd_mem_q, rd_mem_d;
   logic [DEPTH-1:0][XLEN-1:0]     data_mem_q, data_mem_d;
   logic [DEPTH-1:0]               valid_q, valid_d;
   logic [PTR_W-1:0]               wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]               rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]               count_q, count_d;

   // Advance a pointer with explicit wrap at DEPTH-1.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(DEPTH - 1)) begin
         return {PTR_W{1'b0}};
      end else begin
         return p + PTR_W'(1);
      end
   endfunction

   // Next-state for storage, pointers and occupancy; pop is applied before push so a full FIFO can do both.
   always_comb begin
      rd_mem_d   = rd_mem_q;
      data_mem_d = data_mem_q;
      valid_d    = valid_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;

      if (pop_i) begin
         valid_d[rd_ptr_q] = 1'b0;
         rd_ptr_d          = ptr_inc(rd_ptr_q);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end

      if (push_i) begin
         rd_mem_d[wr_ptr_q]   = push_rd_i;
         data_mem_d[wr_ptr_q] = push_data_i;
         valid_d[wr_ptr_q]    = 1'b1;
         wr_ptr_d             = ptr_inc(wr_ptr_q);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end

      case ({push_i, pop_i})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // FIFO state registers with synchronous reset that discards all queued entries.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_mem_q   <= {(DEPTH*REG_SIZE){1'b0}};
         data_mem_q <= {(DEPTH*XLEN){1'b0}};
         valid_q    <= {DEPTH{1'b0}};
         wr_ptr_q   <= {PTR_W{1'b0}};
         rd_ptr_q   <= {PTR_W{1'b0}};
         count_q    <= {CNT_W{1'b0}};
      end else begin
         rd_mem_q   <= rd_mem_d;
         data_mem_q <= data_mem_d;
         valid_q    <= valid_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
      end
   end

   assign head_rd_o     = rd_mem_q[rd_ptr_q];
   assign head_data_o   = data_mem_q[rd_ptr_q];
   assign count_o       = count_q;
   assign empty_o       = (count_q == {CNT_W{1'b0}});
   assign full_o        = (count_q == CNT_W'(DEPTH));
   assign entry_valid_o = valid_q;
   assign entry_rd_o    = rd_mem_q;

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: the short pipe (ALU/LSU) always owns the register
// write port; MDU results that collide are parked in wb_mdu_fifo and
// drained on idle cycles, with the MDU back-pressured when it is full.
// Optional RAW query against parked results: define WB_RAW_CHECK_EN.
module wb_arbiter
   import wb_arbiter_pkg::*;
#(
   parameter int XLEN        = ZCRV_XLEN,
   parameter int REG_SIZE    = ZCRV_REG_SIZE,
   parameter int MDU_Q_DEPTH = 2,
   localparam int CNT_W      = $clog2(MDU_Q_DEPTH + 1)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                error_from_eiu,
   input  logic                alu_wb_en,
   input  logic [REG_SIZE-1:0] alu_rd,
   input  logic [XLEN-1:0]     alu_data,
   input  logic                lsu_wb_en,
   input  logic [REG_SIZE-1:0] lsu_rd,
   input  logic [XLEN-1:0]     lsu_data,
   input  logic                lsu_retire,
   input  logic                mdu_finish,
   input  logic [REG_SIZE-1:0] mdu_rd,
   input  logic [XLEN-1:0]     mdu_data,
   output logic                mdu_ready,
   output logic                rd_en_to_reg,
   output logic [REG_SIZE-1:0] rd_index_to_reg,
   output logic [XLEN-1:0]     rd_data_to_reg,
   output logic                inst_finish_to_csr,
   output logic [CNT_W-1:0]    mdu_q_count,
   input  logic [REG_SIZE-1:0] rs1_q,
   input  logic [REG_SIZE-1:0] rs2_q,
   output logic                raw_hazard
);

   logic                                 short_s;
   logic                                 mdu_ready_s;
   logic                                 push_s;
   logic                                 pop_s;
   wb_src_e                              src_s;
   logic [REG_SIZE-1:0]                  sel_rd_s;
   logic [XLEN-1:0]                      sel_data_s;
   logic                                 writes_s;
   logic                                 hazard_s;

   logic [REG_SIZE-1:0]                  q_head_rd_s;
   logic [XLEN-1:0]                      q_head_data_s;
   logic [CNT_W-1:0]                     q_count_s;
   logic                                 q_empty_s;
   logic                                 q_full_s;
   logic [MDU_Q_DEPTH-1:0]               q_valid_s;
   logic [MDU_Q_DEPTH-1:0][REG_SIZE-1:0] q_rd_s;

   logic                rd_en_q, rd_en_d;
   logic [REG_SIZE-1:0] rd_index_q, rd_index_d;
   logic [XLEN-1:0]     rd_data_q, rd_data_d;
   logic                inst_finish_q, inst_finish_d;

   assign short_s     = (alu_wb_en | lsu_wb_en) & ~error_from_eiu;
   // The MDU only stalls when the short pipe holds the port and there is no room to park.
   assign mdu_ready_s = (q_count_s < CNT_W'(MDU_Q_DEPTH)) | ~short_s;
   assign push_s      = mdu_finish & mdu_ready_s & (src_s != WB_SRC_MDUBYP);

   wb_mdu_fifo #(
      .XLEN     (XLEN),
      .REG_SIZE (REG_SIZE),
      .DEPTH    (MDU_Q_DEPTH)
   ) u_mdu_fifo (
      .clk           (clk),
      .rst           (rst),
      .push_i        (push_s),
      .push_rd_i     (mdu_rd),
      .push_data_i   (mdu_data),
      .pop_i         (pop_s),
      .head_rd_o     (q_head_rd_s),
      .head_data_o   (q_head_data_s),
      .count_o       (q_count_s),
      .empty_o       (q_empty_s),
      .full_o        (q_full_s),
      .entry_valid_o (q_valid_s),
      .entry_rd_o    (q_rd_s)
   );

   wb_arbiter_chk u_chk (
      .clk       (clk),
      .rst       (rst),
      .alu_wb_en (alu_wb_en),
      .lsu_wb_en (lsu_wb_en),
      .push      (push_s),
      .pop       (pop_s),
      .full      (q_full_s),
      .empty     (q_empty_s)
   );

   // Port selection: short pipe, then parked MDU head, then MDU bypass when nothing is parked.
   always_comb begin
      src_s      = WB_SRC_NONE;
      sel_rd_s   = {REG_SIZE{1'b0}};
      sel_data_s = {XLEN{1'b0}};
      pop_s      = 1'b0;
      if (short_s) begin
         if (alu_wb_en) begin
            src_s      = WB_SRC_ALU;
            sel_rd_s   = alu_rd;
            sel_data_s = alu_data;
         end else begin
            src_s      = WB_SRC_LSU;
            sel_rd_s   = lsu_rd;
            sel_data_s = lsu_data;
         end
      end else if (!q_empty_s) begin
         src_s      = WB_SRC_MDUQ;
         sel_rd_s   = q_head_rd_s;
         sel_data_s = q_head_data_s;
         pop_s      = 1'b1;
      end else if (mdu_finish) begin
         src_s      = WB_SRC_MDUBYP;
         sel_rd_s   = mdu_rd;
         sel_data_s = mdu_data;
      end else begin
         src_s = WB_SRC_NONE;
      end
   end

   // Next register-port values; x0 writes are suppressed but still retire.
   always_comb begin
      writes_s = wb_src_writes(src_s);
      if (writes_s) begin
         rd_en_d    = (sel_rd_s != {REG_SIZE{1'b0}});
         rd_index_d = sel_rd_s;
         rd_data_d  = sel_data_s;
      end else begin
         rd_en_d    = 1'b0;
         rd_index_d = {REG_SIZE{1'b0}};
         rd_data_d  = {XLEN{1'b0}};
      end
      inst_finish_d = writes_s | (alu_wb_en & ~error_from_eiu) | lsu_retire;
   end

   // Registered write port and retire pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_en_q       <= 1'b0;
         rd_index_q    <= {REG_SIZE{1'b0}};
         rd_data_q     <= {XLEN{1'b0}};
         inst_finish_q <= 1'b0;
      end else begin
         rd_en_q       <= rd_en_d;
         rd_index_q    <= rd_index_d;
         rd_data_q     <= rd_data_d;
         inst_finish_q <= inst_finish_d;
      end
   end

`ifdef WB_RAW_CHECK_EN
   // Nonzero destination matching either source query.
   function automatic logic rd_hit(input logic [REG_SIZE-1:0] rd,
                                   input logic [REG_SIZE-1:0] a,
                                   input logic [REG_SIZE-1:0] b);
      return (rd != {REG_SIZE{1'b0}}) && ((rd == a) || (rd == b));
   endfunction

   // RAW query over parked entries plus the result being parked this cycle.
   always_comb begin
      hazard_s = 1'b0;
      for (int i = 0; i < MDU_Q_DEPTH; i++) begin
         if (q_valid_s[i] && rd_hit(q_rd_s[i], rs1_q, rs2_q)) begin
            hazard_s = 1'b1;
         end else begin
            hazard_s = hazard_s;
         end
      end
      if (push_s && rd_hit(mdu_rd, rs1_q, rs2_q)) begin
         hazard_s = 1'b1;
      end else begin
         hazard_s = hazard_s;
      end
   end
`else
   logic unused_hazard_s;
   assign unused_hazard_s = ^{rs1_q, rs2_q, q_valid_s, q_rd_s};
   assign hazard_s        = 1'b0;
`endif

   assign mdu_ready          = mdu_ready_s;
   assign rd_en_to_reg       = rd_en_q;
   assign rd_index_to_reg    = rd_index_q;
   assign rd_data_to_reg     = rd_data_q;
   assign inst_finish_to_csr = inst_finish_q;
   assign mdu_q_count        = q_count_s;
   assign raw_hazard         = hazard_s;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios followed by
// random traffic, all checked against a queue-based reference model.
module tb_wb_arbiter;

   localparam int XLEN  = 32;
   localparam int RS    = 5;
   localparam int DEPTH = 2;
   localparam int CW    = $clog2(DEPTH + 1);
`ifdef WB_RAW_CHECK_EN
   localparam logic HAZ_EN = 1'b1;
`else
   localparam logic HAZ_EN = 1'b0;
`endif

   logic            clk;
   logic            rst;
   logic            error_from_eiu;
   logic            alu_wb_en;
   logic [RS-1:0]   alu_rd;
   logic [XLEN-1:0] alu_data;
   logic            lsu_wb_en;
   logic [RS-1:0]   lsu_rd;
   logic [XLEN-1:0] lsu_data;
   logic            lsu_retire;
   logic            mdu_finish;
   logic [RS-1:0]   mdu_rd;
   logic [XLEN-1:0] mdu_data;
   logic            mdu_ready;
   logic            rd_en_to_reg;
   logic [RS-1:0]   rd_index_to_reg;
   logic [XLEN-1:0] rd_data_to_reg;
   logic            inst_finish_to_csr;
   logic [CW-1:0]   mdu_q_count;
   logic [RS-1:0]   rs1_q;
   logic [RS-1:0]   rs2_q;
   logic            raw_hazard;

   wb_arbiter #(.XLEN(XLEN), .REG_SIZE(RS), .MDU_Q_DEPTH(DEPTH)) dut (
      .clk                (clk),
      .rst                (rst),
      .error_from_eiu     (error_from_eiu),
      .alu_wb_en          (alu_wb_en),
      .alu_rd             (alu_rd),
      .alu_data           (alu_data),
      .lsu_wb_en          (lsu_wb_en),
      .lsu_rd             (lsu_rd),
      .lsu_data           (lsu_data),
      .lsu_retire         (lsu_retire),
      .mdu_finish         (mdu_finish),
      .mdu_rd             (mdu_rd),
      .mdu_data           (mdu_data),
      .mdu_ready          (mdu_ready),
      .rd_en_to_reg       (rd_en_to_reg),
      .rd_index_to_reg    (rd_index_to_reg),
      .rd_data_to_reg     (rd_data_to_reg),
      .inst_finish_to_csr (inst_finish_to_csr),
      .mdu_q_count        (mdu_q_count),
      .rs1_q              (rs1_q),
      .rs2_q              (rs2_q),
      .raw_hazard         (raw_hazard)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference model state: parked MDU results as {rd, data}, oldest first.
   logic [RS+XLEN-1:0] mq[$];
   // Pending MDU result held by the producer until accepted.
   logic            m_fin = 1'b0;
   logic [RS-1:0]   m_rd  = '0;
   logic [XLEN-1:0] m_dat = '0;

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic hit(input logic [RS-1:0] rd, input logic [RS-1:0] a, input logic [RS-1:0] b);
      return (rd != 0) && (rd == a || rd == b);
   endfunction

   // One clock cycle: drive inputs, check combinational outputs, advance the model, check registered outputs.
   task automatic step(input logic r, input logic err,
                       input logic ae, input logic [RS-1:0] ard, input logic [XLEN-1:0] adat,
                       input logic le, input logic [RS-1:0] lrd, input logic [XLEN-1:0] ldat,
                       input logic lret, input logic [RS-1:0] r1, input logic [RS-1:0] r2);
      logic            short_v, ready_v, bypass_v, haz_v, wr_v;
      logic [RS-1:0]   widx;
      logic [XLEN-1:0] wdat;
      logic            e_en, e_fin;
      logic [RS-1:0]   e_idx;
      logic [XLEN-1:0] e_dat;
      logic [RS+XLEN-1:0] ent;

      rst = r; error_from_eiu = err;
      alu_wb_en = ae; alu_rd = ard; alu_data = adat;
      lsu_wb_en = le; lsu_rd = lrd; lsu_data = ldat; lsu_retire = lret;
      mdu_finish = m_fin; mdu_rd = m_rd; mdu_data = m_dat;
      rs1_q = r1; rs2_q = r2;
      #1;
      short_v  = (ae || le) && !err;
      ready_v  = (mq.size() < DEPTH) || !short_v;
      bypass_v = !short_v && mq.size() == 0 && m_fin;
      chk_eq("mdu_ready", 32'(mdu_ready), 32'(ready_v));

      haz_v = 1'b0;
      if (HAZ_EN) begin
         foreach (mq[i]) if (hit(mq[i][RS+XLEN-1:XLEN], r1, r2)) haz_v = 1'b1;
         if (m_fin && ready_v && !bypass_v && hit(m_rd, r1, r2)) haz_v = 1'b1;
      end
      chk_eq("raw_hazard", 32'(raw_hazard), 32'(haz_v));

      wr_v = 1'b0; widx = '0; wdat = '0;
      if (r) begin
         mq.delete();
         m_fin = 1'b0;
         e_en = 1'b0; e_idx = '0; e_dat = '0; e_fin = 1'b0;
      end else begin
         if (short_v) begin
            wr_v = 1'b1;
            if (ae) begin widx = ard; wdat = adat; end
            else    begin widx = lrd; wdat = ldat; end
         end else if (mq.size() > 0) begin
            ent  = mq.pop_front();
            wr_v = 1'b1; widx = ent[RS+XLEN-1:XLEN]; wdat = ent[XLEN-1:0];
         end else if (m_fin) begin
            wr_v = 1'b1; widx = m_rd; wdat = m_dat;
         end
         if (m_fin && ready_v) begin
            if (!bypass_v) mq.push_back({m_rd, m_dat});
            m_fin = 1'b0;
         end
         e_en  = wr_v && widx != 0;
         e_idx = wr_v ? widx : '0;
         e_dat = wr_v ? wdat : '0;
         e_fin = wr_v || (ae && !err) || lret;
      end

      @(posedge clk);
      #1;
      chk_eq("rd_en",  32'(rd_en_to_reg), 32'(e_en));
      chk_eq("rd_idx", 32'(rd_index_to_reg), 32'(e_idx));
      chk_eq("rd_data", rd_data_to_reg, e_dat);
      chk_eq("finish", 32'(inst_finish_to_csr), 32'(e_fin));
      chk_eq("count",  32'(mdu_q_count), 32'(mq.size()));
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, '0);
   endtask

   task automatic alu(input logic [RS-1:0] rd, input logic [XLEN-1:0] d);
      step(1'b0, 1'b0, 1'b1, rd, d, 1'b0, '0, '0, 1'b0, '0, '0);
   endtask

   task automatic mdu_load(input logic [RS-1:0] rd, input logic [XLEN-1:0] d);
      m_fin = 1'b1; m_rd = rd; m_dat = d;
   endtask

   initial begin
      rst = 1'b1; error_from_eiu = 1'b0;
      alu_wb_en = 1'b0; alu_rd = '0; alu_data = '0;
      lsu_wb_en = 1'b0; lsu_rd = '0; lsu_data = '0; lsu_retire = 1'b0;
      mdu_finish = 1'b0; mdu_rd = '0; mdu_data = '0;
      rs1_q = '0; rs2_q = '0;

      // Reset state
      step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, '0);
      step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, '0);
      chk_eq("rst_ready", 32'(mdu_ready), 32'd1);

      // Plain ALU write
      alu(5'd5, 32'h11);
      chk_eq("alu_idx", 32'(rd_index_to_reg), 32'd5);
      chk_eq("alu_data", rd_data_to_reg, 32'h11);

      // MDU collides with ALU, then drains on idle
      mdu_load(5'd7, 32'hAA);
      alu(5'd3, 32'h33);
      chk_eq("coll_idx", 32'(rd_index_to_reg), 32'd3);
      chk_eq("coll_cnt", 32'(mdu_q_count), 32'd1);
      idle();
      chk_eq("drain_idx", 32'(rd_index_to_reg), 32'd7);
      chk_eq("drain_data", rd_data_to_reg, 32'hAA);

      // Fill to full, back-pressure, ordered drain
      mdu_load(5'd8, 32'h80);
      alu(5'd1, 32'h1);
      mdu_load(5'd9, 32'h90);
      alu(5'd2, 32'h2);
      mdu_load(5'd10, 32'hA0);
      alu(5'd3, 32'h3);
      chk_eq("full_cnt", 32'(mdu_q_count), 32'd2);
      alu(5'd4, 32'h4);
      idle();
      chk_eq("ord0", 32'(rd_index_to_reg), 32'd8);
      idle();
      chk_eq("ord1", 32'(rd_index_to_reg), 32'd9);
      idle();
      chk_eq("ord2", 32'(rd_index_to_reg), 32'd10);
      chk_eq("ord2_data", rd_data_to_reg, 32'hA0);

      // Squashed ALU lets the MDU bypass
      mdu_load(5'd6, 32'h66);
      step(1'b0, 1'b1, 1'b1, 5'd4, 32'h44, 1'b0, '0, '0, 1'b0, '0, '0);
      chk_eq("byp_idx", 32'(rd_index_to_reg), 32'd6);
      chk_eq("byp_fin", 32'(inst_finish_to_csr), 32'd1);

      // Reset discards a full queue
      mdu_load(5'd11, 32'hB0);
      alu(5'd1, 32'h1);
      mdu_load(5'd12, 32'hC0);
      alu(5'd2, 32'h2);
      step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, '0);
      chk_eq("rst_cnt", 32'(mdu_q_count), 32'd0);
      idle();
      chk_eq("rst_stale", 32'(rd_en_to_reg), 32'd0);

      // RAW query against a parked x9 and a parked x0
      mdu_load(5'd9, 32'h99);
      alu(5'd1, 32'h1);
      rs1_q = 5'd9; #1;
      chk_eq("haz_x9", 32'(raw_hazard), 32'(HAZ_EN));
      idle();
      mdu_load(5'd0, 32'h5);
      alu(5'd1, 32'h1);
      rs1_q = 5'd0; rs2_q = 5'd0; #1;
      chk_eq("haz_x0", 32'(raw_hazard), 32'd0);
      idle();

      // Random traffic
      for (int n = 0; n < 400; n++) begin
         int sel;
         logic r, err, ae, le;
         sel = $urandom_range(0, 3);
         ae  = (sel == 1);
         le  = (sel == 2);
         err = ($urandom_range(0, 7) == 0);
         r   = ($urandom_range(0, 96) == 0);
         if (!m_fin && $urandom_range(0, 2) == 0)
            mdu_load(5'($urandom_range(0, 15)), $urandom);
         step(r, err, ae, 5'($urandom_range(0, 15)), $urandom,
              le, 5'($urandom_range(0, 15)), $urandom,
              ($urandom_range(0, 3) == 0),
              5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
